debounce_sync: RTL and testbench

Conditioning stage directly upstream of the team's asynchronous-reset D flip-flop stage. It takes a raw, asynchronous, bouncy input (pushbutton or switch) and synchronises it into the clk domain. It filters the input with a stable-time counter and drives a clean level on d_out, which feeds the FF's d input. It also produces single-cycle rise and fall pulses for control logic.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/sync_chain.sv | 24 ++
 rtl/debounce_sync.sv | 143 ++++++++++++++
 tb/tb_debounce_sync.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce/synchroniser block.
package debounce_pkg;

  // Filter state. Bit 1 equals the debounced level of the state, so the
  // two HIGH-side states (IDLE_HIGH, WAIT_LOW) share d_out = 1.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    WAIT_LOW  = 2'b10
  } state_t;

  // Width of the stable-time counter: wide enough to hold STABLE_CYCLES.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain flop chain that brings an asynchronous level into the clk domain.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the raw input through SYNC_STAGES flops with no logic in between.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronises a bouncy input, filters it with a stable-time counter and
// produces a clean level plus one-cycle rise/fall pulses.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic d_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  // Synchronised input: the only view of btn_in the filter ever uses.
  logic w_s;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_d_out;
  logic          w_d_out_next;
  logic          r_rise;
  logic          w_rise_next;
  logic          r_fall;
  logic          w_fall_next;
  logic          r_busy;
  logic          w_busy_next;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (btn_in),
    .o_q  (w_s)
  );

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE_LOW;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Registered outputs; busy is registered from the next state so it is
  // high exactly while the state register holds a WAIT state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d_out <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_d_out <= w_d_out_next;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
      r_busy  <= w_busy_next;
    end
  end

  // Next-state, counter and output decode. A WAIT state that sees the
  // original level again drops straight back to its IDLE state, so the next
  // change always restarts counting from 1.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_d_out_next = r_d_out;
    w_rise_next  = 1'b0;
    w_fall_next  = 1'b0;

    case (r_state)
      IDLE_LOW: begin
        if (w_s) begin
          w_state_next = WAIT_HIGH;
          w_cnt_next   = CNT_ONE;
        end
      end

      WAIT_HIGH: begin
        if (!w_s) begin
          w_state_next = IDLE_LOW;
          w_cnt_next   = CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE_HIGH;
          w_cnt_next   = CNT_ZERO;
          w_d_out_next = 1'b1;
          w_rise_next  = 1'b1;
        end else begin
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end

      IDLE_HIGH: begin
        if (!w_s) begin
          w_state_next = WAIT_LOW;
          w_cnt_next   = CNT_ONE;
        end
      end

      WAIT_LOW: begin
        if (w_s) begin
          w_state_next = IDLE_HIGH;
          w_cnt_next   = CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE_LOW;
          w_cnt_next   = CNT_ZERO;
          w_d_out_next = 1'b0;
          w_fall_next  = 1'b1;
        end else begin
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_next = IDLE_LOW;
        w_cnt_next   = CNT_ZERO;
        w_d_out_next = 1'b0;
      end
    endcase

    w_busy_next = (w_state_next == WAIT_HIGH) || (w_state_next == WAIT_LOW);
  end

  assign d_out      = r_d_out;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign busy       = r_busy;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with SYNC_STAGES=2, STABLE_CYCLES=4.
// Output vectors are packed as {d_out, rise_pulse, fall_pulse, busy}.
module tb_debounce_sync;

  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned STABLE_CYCLES = 4;

  logic clk;
  logic reset;
  logic btn_in;
  logic d_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  int total;
  int bad;

  typedef struct {
    logic       btn;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  debounce_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .d_out     (d_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy      (busy)
  );

  // Clock and run-time watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the test ended");
    $fatal(1, "watchdog");
  end

  // Driver helpers.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic b, input logic [3:0] e);
    vec_t v;
    v.btn = b;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {d,rise,fall,busy}=%b want=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] outs();
    return {d_out, rise_pulse, fall_pulse, busy};
  endfunction

  // Pulse reset between clock edges and check outputs clear before any edge.
  task automatic async_reset(input string name);
    #3;
    reset = 1'b1;
    #1;
    chk(name, outs(), 4'b0000);
    #1;
    reset = 1'b0;
  endtask

  // btn_in already 1 and state IDLE_LOW: full rising latency from edge 1.
  task automatic check_full_rise(input string name);
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("%s_e%0d", name, e), outs(),
          {(e >= 6), (e == 6), 1'b0, (e >= 3 && e <= 5)});
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    btn_in = 1'b0;
    reset  = 1'b1;

    // Rising edge, held (edges 1..8).
    add_vec(1'b1, 4'b0000); add_vec(1'b1, 4'b0000); add_vec(1'b1, 4'b0001);
    add_vec(1'b1, 4'b0001); add_vec(1'b1, 4'b0001); add_vec(1'b1, 4'b1100);
    add_vec(1'b1, 4'b1000); add_vec(1'b1, 4'b1000);
    // Falling edge, held; rise_pulse stays 0.
    add_vec(1'b0, 4'b1000); add_vec(1'b0, 4'b1000); add_vec(1'b0, 4'b1001);
    add_vec(1'b0, 4'b1001); add_vec(1'b0, 4'b1001); add_vec(1'b0, 4'b0010);
    add_vec(1'b0, 4'b0000); add_vec(1'b0, 4'b0000);
    // Bounce 1,1,0 then 1 held: WAIT aborted, count restarts from 1.
    add_vec(1'b1, 4'b0000); add_vec(1'b1, 4'b0000); add_vec(1'b0, 4'b0001);
    add_vec(1'b1, 4'b0001); add_vec(1'b1, 4'b0000); add_vec(1'b1, 4'b0001);
    add_vec(1'b1, 4'b0001); add_vec(1'b1, 4'b0001); add_vec(1'b1, 4'b1100);
    add_vec(1'b1, 4'b1000);

    // Reset state.
    tick();
    tick();
    chk("reset_state", outs(), 4'b0000);
    #4;
    reset = 1'b0;
    tick();
    chk("after_release_idle", outs(), 4'b0000);

    // Table-driven main sequence.
    for (int i = 0; i < vecs.size(); i++) begin
      btn_in = vecs[i].btn;
      tick();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // d_out=1, btn_in=1: async reset clears everything between edges, then
    // btn_in held through release is a fresh rising event.
    async_reset("async_reset_from_high");
    check_full_rise("rise_after_release");

    // Reach WAIT_HIGH with cnt=2, then reset mid-WAIT.
    btn_in = 1'b0;
    async_reset("reset_to_low");
    tick();
    tick();
    btn_in = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    chk("in_wait_high_cnt2", outs(), 4'b0001);
    async_reset("reset_mid_wait");
    check_full_rise("rise_after_mid_wait_reset");

    // Reset while rise_pulse is high drops the pulse immediately.
    async_reset("reset_before_pulse_case");
    for (int e = 1; e <= 6; e++) tick();
    chk("pulse_present", outs(), 4'b1100);
    btn_in = 1'b0;
    async_reset("reset_mid_pulse");

    // Single-cycle glitch every 3 cycles: busy blips once per glitch on the
    // third edge of each group, nothing else moves.
    tick();
    tick();
    for (int g = 0; g < 50; g++) begin
      for (int k = 0; k < 3; k++) begin
        btn_in = (k == 0);
        tick();
        chk($sformatf("glitch%0d_k%0d", g, k), outs(), {3'b000, (k == 2)});
      end
    end
    tick();
    tick();
    chk("after_glitches", outs(), 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
